// File: rtl/exu_mdu_pkg.sv
// Shared definitions for the EXU multiply-divide unit: FSM encodings, M-extension
// func3 names and the OP-class opcode/func7 that route an instruction here.
package exu_mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [6:0] OPC_OP          = 7'b0110011;
  localparam logic [6:0] FUNC7_0_000_001 = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/exu_mdu_iter_step.sv
// One combinational iteration of UNROLL bits: shift-add for multiply, restoring
// shift-subtract for divide. {acc, a} is the working register pair in both cases.
module exu_mdu_iter_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            is_div_in,
  input  logic [XLEN:0]   acc_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN:0]   acc_out,
  output logic [XLEN-1:0] a_out
);

  logic [XLEN:0]   acc;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] a;

  always_comb begin
    acc   = acc_in;
    a     = a_in;
    trial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div_in) begin
        acc   = {acc[XLEN-1:0], a[XLEN-1]};
        a     = {a[XLEN-2:0], 1'b0};
        // borrow out of the top bit means the divisor did not fit
        trial = acc - {1'b0, b_in};
        if (!trial[XLEN]) begin
          acc  = trial;
          a[0] = 1'b1;
        end
      end else begin
        if (a[0]) acc = acc + {1'b0, b_in};
        a   = {acc[0], a[XLEN-1:1]};
        acc = {1'b0, acc[XLEN:1]};
      end
    end
    acc_out = acc;
    a_out   = a;
  end

endmodule

// File: rtl/exu_mdu.sv
// Iterative RV32M/RV64M multiply-divide unit with valid/ready request and response.
//   state | meaning
//   IDLE  | ready for a request
//   PREP  | take magnitudes, record sign, catch div-by-zero / overflow
//   CALC  | retire UNROLL bits per cycle
//   FIX   | apply sign, select result half
//   DONE  | response valid, held until consumed
module exu_mdu
  import exu_mdu_pkg::*;
#(
  parameter int XLEN    = MDU_XLEN,
  parameter int XREG_AW = 5,
  parameter int UNROLL  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_in,
  input  logic               req_valid_in,
  output logic               req_ready_out,
  input  logic [2:0]         func3_in,
  input  logic [XLEN-1:0]    rs1_in,
  input  logic [XLEN-1:0]    rs2_in,
  input  logic [XREG_AW-1:0] rd_addr_in,
  output logic               resp_valid_out,
  input  logic               resp_ready_in,
  output logic [XLEN-1:0]    rd_out,
  output logic [XREG_AW-1:0] rd_addr_out,
  output logic               rd_en_out,
  output logic               busy_out
);

  localparam int CW = $clog2(XLEN / UNROLL);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN / UNROLL - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e         state_q, state_d;
  logic [2:0]         func3_q, func3_d;
  logic [XREG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [XLEN:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic [XLEN:0]      step_acc;
  logic [XLEN-1:0]    step_a;
  logic               is_div, s1, s2, div0, ovf;
  logic [2*XLEN-1:0]  prod, prod_s;
  logic [XLEN-1:0]    quo_s, rem_s;

  exu_mdu_iter_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div_in (is_div),
    .acc_in    (acc_q),
    .a_in      (a_q),
    .b_in      (b_q),
    .acc_out   (step_acc),
    .a_out     (step_a)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      func3_q   <= '0;
      rd_addr_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      func3_q   <= func3_d;
      rd_addr_q <= rd_addr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
    end
  end

  // Operand classification on the raw operands latched at accept
  always_comb begin
    is_div = func3_q[2];
    s1     = a_q[XLEN-1] && (func3_q != F3_MULHU) && (func3_q != F3_DIVU) && (func3_q != F3_REMU);
    s2     = b_q[XLEN-1] && ((func3_q == F3_MUL) || (func3_q == F3_MULH) ||
                             (func3_q == F3_DIV) || (func3_q == F3_REM));
    div0   = is_div && (b_q == '0);
    ovf    = is_div && !func3_q[0] && (a_q == MOST_NEG) && (&b_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_in)   state_d = ST_PREP;
      ST_PREP: state_d = (div0 || ovf) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == '0)    state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (resp_ready_in)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_in) state_d = ST_IDLE;
  end

  always_comb begin
    prod   = {acc_q[XLEN-1:0], a_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -a_q : a_q;
    rem_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    func3_d   = func3_q;
    rd_addr_d = rd_addr_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in && !flush_in) begin
          func3_d   = func3_in;
          rd_addr_d = rd_addr_in;
          a_d       = rs1_in;
          b_d       = rs2_in;
        end
      end
      ST_PREP: begin
        a_d   = s1 ? -a_q : a_q;
        b_d   = s2 ? -b_q : b_q;
        acc_d = '0;
        cnt_d = CNT_INIT;
        neg_d = (is_div && func3_q[1]) ? s1 : (s1 ^ s2);
        if (div0)     result_d = func3_q[1] ? a_q : '1;
        else if (ovf) result_d = func3_q[1] ? '0 : a_q;
      end
      ST_CALC: begin
        acc_d = step_acc;
        a_d   = step_a;
        cnt_d = cnt_q - CW'(1);
      end
      ST_FIX: begin
        case (func3_q)
          F3_MUL:                       result_d = prod_s[XLEN-1:0];
          F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
          F3_DIV, F3_DIVU:              result_d = quo_s;
          default:                      result_d = rem_s;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready_out  = (state_q == ST_IDLE);
    resp_valid_out = (state_q == ST_DONE);
    busy_out       = (state_q != ST_IDLE);
    rd_en_out      = resp_valid_out && (rd_addr_q != '0);
  end

  assign rd_out      = result_q;
  assign rd_addr_out = rd_addr_q;

endmodule

// File: tb/tb_exu_mdu.sv
// Directed-vector bench for exu_mdu (XLEN=32, UNROLL=1) with hold, flush and
// mid-operation reset sequences.
module tb_exu_mdu;
  import exu_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [2:0]  func3_in = '0;
  logic [31:0] rs1_in = '0;
  logic [31:0] rs2_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        resp_valid_out;
  logic        resp_ready_in = 1'b0;
  logic [31:0] rd_out;
  logic [4:0]  rd_addr_out;
  logic        rd_en_out;
  logic        busy_out;

  int n_checks = 0;
  int n_fail = 0;

  exu_mdu #(.XLEN(32), .XREG_AW(5), .UNROLL(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_in       (flush_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .func3_in       (func3_in),
    .rs1_in         (rs1_in),
    .rs2_in         (rs2_in),
    .rd_addr_in     (rd_addr_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .rd_out         (rd_out),
    .rd_addr_out    (rd_addr_out),
    .rd_en_out      (rd_en_out),
    .busy_out       (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  {63'd0, req_ready_out},  64'd1);
    check({tag, " resp_valid"}, {63'd0, resp_valid_out}, 64'd0);
    check({tag, " busy"},       {63'd0, busy_out},       64'd0);
    check({tag, " rd_en"},      {63'd0, rd_en_out},      64'd0);
    check({tag, " rd_out"},     {32'd0, rd_out},         64'd0);
    check({tag, " rd_addr"},    {59'd0, rd_addr_out},    64'd0);
  endtask

  task automatic send_req(input vec_t v);
    @(negedge clk);
    req_valid_in = 1'b1;
    func3_in     = v.f3;
    rs1_in       = v.rs1;
    rs2_in       = v.rs2;
    rd_addr_in   = v.rd;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid_out && lat < 200);
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int lat;
    send_req(v);
    wait_valid(lat);
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " rd_out"}, {32'd0, rd_out}, {32'd0, v.exp});
    check({tag, " rd_addr"}, {59'd0, rd_addr_out}, {59'd0, v.rd});
    check({tag, " rd_en"}, {63'd0, rd_en_out}, {63'd0, (v.rd != 5'd0)});
    @(negedge clk);
    resp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_in = 1'b0;
    check({tag, " valid drop"}, {63'd0, resp_valid_out}, 64'd0);
    check({tag, " ready back"}, {63'd0, req_ready_out}, 64'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    vec_t v;

    vecs.push_back('{F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34});
    vecs.push_back('{F3_MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34});
    vecs.push_back('{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34});
    vecs.push_back('{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34});
    vecs.push_back('{F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34});
    vecs.push_back('{F3_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34});
    vecs.push_back('{F3_DIVU,   32'hFFFFFFF9, 32'd2,        5'd11, 32'h7FFFFFFC, 34});
    vecs.push_back('{F3_DIVU,   32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1});
    vecs.push_back('{F3_REM,    32'd5,        32'd0,        5'd13, 32'd5,        1});
    vecs.push_back('{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1});
    vecs.push_back('{F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1});
    vecs.push_back('{F3_MUL,    32'd3,        32'd4,        5'd0,  32'd12,       34});
    vecs.push_back('{F3_MULH,   32'd3,        32'hFFFFFFFC, 5'd16, 32'hFFFFFFFF, 34});
    vecs.push_back('{F3_MULHU,  32'h80000000, 32'd4,        5'd17, 32'd2,        34});
    vecs.push_back('{F3_MUL,    32'h12345678, 32'h10,       5'd18, 32'h23456780, 34});
    vecs.push_back('{F3_DIV,    32'd100,      32'hFFFFFFF9, 5'd19, 32'hFFFFFFF2, 34});
    vecs.push_back('{F3_REM,    32'd100,      32'hFFFFFFF9, 5'd20, 32'd2,        34});
    vecs.push_back('{F3_DIV,    32'hFFFFFF9C, 32'hFFFFFFF9, 5'd21, 32'd14,       34});
    vecs.push_back('{F3_REM,    32'hFFFFFF9C, 32'hFFFFFFF9, 5'd22, 32'hFFFFFFFE, 34});
    vecs.push_back('{F3_REMU,   32'd100,      32'd7,        5'd23, 32'd2,        34});
    vecs.push_back('{F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd24, 32'd0,        34});
    vecs.push_back('{F3_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd25, 32'h80000000, 34});
    vecs.push_back('{F3_DIV,    32'd0,        32'd0,        5'd26, 32'hFFFFFFFF, 1});
    vecs.push_back('{F3_REMU,   32'd9,        32'd0,        5'd27, 32'd9,        1});

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i], $sformatf("v%0d", i));

    // Response held back by the consumer
    v = '{F3_MUL, 32'd6, 32'd7, 5'd3, 32'd42, 34};
    send_req(v);
    wait_valid(lat);
    check("hold latency", 64'(lat), 64'd34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold rd_out", {32'd0, rd_out}, 64'd42);
      check("hold req_ready", {63'd0, req_ready_out}, 64'd0);
      check("hold resp_valid", {63'd0, resp_valid_out}, 64'd1);
    end
    @(negedge clk);
    resp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_in = 1'b0;
    check("hold released", {63'd0, resp_valid_out}, 64'd0);

    // Flush in the fifth CALC cycle
    v = '{F3_DIVU, 32'd1000, 32'd3, 5'd4, 32'd333, 34};
    send_req(v);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    check("flush busy", {63'd0, busy_out}, 64'd0);
    check("flush req_ready", {63'd0, req_ready_out}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid_out) seen = 1'b1;
    end
    check("flush no response", {63'd0, seen}, 64'd0);
    v = '{F3_DIV, 32'd1000, 32'd3, 5'd4, 32'd333, 34};
    do_op(v, "after flush");

    // Asynchronous reset in the middle of CALC
    v = '{F3_MUL, 32'd11, 32'd13, 5'd9, 32'd143, 34};
    send_req(v);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(v, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
